exu_lsu: RTL and testbench
==========================

// Module: exu_lsu
// PURPOSE
//  Load/store unit downstream of the ALU operand decoder. Takes one memory op (type flags,
//  effective address from the shared adder, store data from rs2), does one data-bus transaction,
//  aligns/sign-extends load data, and returns a writeback or exception.
//  One op in flight; the pipeline stalls on o_lsu_ready=0.
// PARAMETERS
//  RSP_TIMEOUT  256  cycles in S_RSP before access fault; 0 disables the timeout
// PORTS
//  i_clk           in   1   clock, rising edge
//  i_rst           in   1   asynchronous, active-high reset
//  i_lsu_valid     in   1   op offered this cycle
//  o_lsu_ready     out  1   1 only in S_IDLE; accept = i_lsu_valid & o_lsu_ready
//  i_mem_wreq      in   1   store op
//  i_mem_rreq      in   1   load op
//  i_mem_wtype     in   3   {sb,sh,sw}, one-hot
//  i_mem_rdtype    in   4   {lb|lh, lbu|lb, lhu|lh, lw}: [3]=signed [2]=byte [1]=half [0]=word
//  i_mem_addr      in   32  effective address rs1+imm
//  i_mem_wdata     in   32  store data (rs2)
//  i_rd_idx        in   5   load destination register
//  o_bus_req_valid out  1   bus request
//  i_bus_req_ready in   1   bus accepts request
//  o_bus_addr      out  32  {addr[31:2],2'b00}
//  o_bus_we        out  1   1 for stores
//  o_bus_wstrb     out  4   byte enables (0000 for loads)
//  o_bus_wdata     out  32  lane-replicated store data
//  i_bus_rsp_valid in   1   response valid
//  i_bus_rdata     in   32  read data (ignored for stores)
//  i_bus_rsp_err   in   1   bus error, qualified by i_bus_rsp_valid
//  o_lsu_done      out  1   one-cycle completion pulse
//  o_wb_en         out  1   with done: load completed without exception
//  o_wb_rd         out  5   dest register
//  o_wb_data       out  32  aligned, extended load data
//  o_exc_misalign  out  1   with done: misaligned address
//  o_exc_access    out  1   with done: bus error or timeout
//  o_exc_store     out  1   with done: exception belongs to a store
//  o_exc_addr      out  32  faulting effective address
// BEHAVIOUR
//  - Reset: state S_IDLE; every output 0 except o_lsu_ready=1. Reset mid-op drops the op; no done.
//  - States: S_IDLE, S_REQ, S_RSP, S_DONE. All outputs registered.
//  - S_IDLE: on accept, latch op/addr/data/rd.
//      Misaligned (half & a[0], or word & a[1:0]!=0) -> S_DONE with misalign; no bus activity.
//      Otherwise -> S_REQ. Accept with neither wreq nor rreq: ignored.
//      Both asserted: store wins.
//  - S_REQ: o_bus_req_valid=1, addr/we/wstrb/wdata held stable until i_bus_req_ready=1, then S_RSP.
//  - S_RSP: waits for i_bus_rsp_valid (a response in the handshake cycle is not sampled).
//      On rsp -> S_DONE; err sets access. Timeout counter starts at 0 on entry;
//      at RSP_TIMEOUT cycles -> S_DONE with access. A late response is ignored.
//  - S_DONE: o_lsu_done=1 for exactly one cycle, then S_IDLE. o_wb_* and o_exc_* valid only here, else 0.
//  - Store lanes:
//      sb: wdata={4{d[7:0]}},  wstrb=4'b0001<<a[1:0]
//      sh: wdata={2{d[15:0]}}, wstrb=a[1]?1100:0011
//      sw: wdata=d,            wstrb=1111
//  - Load: byte=rdata>>(8*a[1:0]), half=rdata>>(16*a[1]); sign- or zero-extend per rdtype[3].
//  - Min latency, aligned op, bus ready immediately, response 1 cycle later: accept c0, req c1,
//    rsp c2, done c3. Misaligned op: done c1.
// TESTING
//  - lb @0x1003, rdata=0x80AA55CC -> c1 req addr 0x1000 wstrb 0; done wb_data=0xFFFFFF80, wb_en=1.
//  - lhu @0x2002, rdata=0xBEEF1234 -> wb_data=0x0000BEEF; lbu @0x2001 -> 0x00000012.
//  - sh @0x2002, d=0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, we=1; done with wb_en=0.
//  - lw @0x1001 -> no req; next cycle done, misalign=1, exc_addr=0x1001; sw @0x1002 also sets exc_store=1.
//  - req_ready low 5 cycles -> req fields stable, ready=0; rsp_err=1 -> done, access=1.
//    No rsp for RSP_TIMEOUT -> access=1.
//  - i_rst pulsed in S_RSP -> all outputs 0 asynchronously, ready=1 after release; late rsp causes no done.

Source files
------------

// File: rtl/exu_lsu.sv
// Load/store unit: one memory op in flight, accept->done in 3 cycles minimum (1 for misaligned).
// o_lsu_ready drops while busy; bus requests hold stable until i_bus_req_ready.
module exu_lsu #(
  parameter int RSP_TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic        i_mem_wreq,
  input  logic        i_mem_rreq,
  input  logic [2:0]  i_mem_wtype,
  input  logic [3:0]  i_mem_rdtype,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [4:0]  i_rd_idx,
  output logic        o_bus_req_valid,
  input  logic        i_bus_req_ready,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_wstrb,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rsp_valid,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_rsp_err,
  output logic        o_lsu_done,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_exc_misalign,
  output logic        o_exc_access,
  output logic        o_exc_store,
  output logic [31:0] o_exc_addr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  localparam int CW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

  state_t state_q, state_d;

  logic          store_q, store_d;
  logic [3:0]    rdtype_q, rdtype_d;
  logic [31:0]   addr_q, addr_d;
  logic [4:0]    rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        ready_q, ready_d;
  logic        req_vld_q, req_vld_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        done_q, done_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_acc_q, exc_acc_d;
  logic        exc_store_q, exc_store_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic        accept, in_op, in_store, in_half, in_word, in_mis, rsp_tmo;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  assign accept   = i_lsu_valid & ready_q;
  assign in_op    = i_mem_wreq | i_mem_rreq;
  assign in_store = i_mem_wreq;
  assign in_half  = in_store ? i_mem_wtype[1] : i_mem_rdtype[1];
  assign in_word  = in_store ? i_mem_wtype[0] : i_mem_rdtype[0];
  assign in_mis   = (in_half & i_mem_addr[0]) | (in_word & (|i_mem_addr[1:0]));
  assign rsp_tmo  = (RSP_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Store lane replication and byte enables
  always_comb begin
    st_wdata = i_mem_wdata;
    st_wstrb = 4'b1111;
    if (i_mem_wtype[2]) begin
      st_wdata = {4{i_mem_wdata[7:0]}};
      st_wstrb = 4'b0001 << i_mem_addr[1:0];
    end else if (i_mem_wtype[1]) begin
      st_wdata = {2{i_mem_wdata[15:0]}};
      st_wstrb = i_mem_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_b = i_bus_rdata[7:0];
      2'd1:    ld_b = i_bus_rdata[15:8];
      2'd2:    ld_b = i_bus_rdata[23:16];
      default: ld_b = i_bus_rdata[31:24];
    endcase
    ld_h    = addr_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    ld_data = 32'h0;
    if (rdtype_q[2])      ld_data = {{24{rdtype_q[3] & ld_b[7]}}, ld_b};
    else if (rdtype_q[1]) ld_data = {{16{rdtype_q[3] & ld_h[15]}}, ld_h};
    else if (rdtype_q[0]) ld_data = i_bus_rdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && in_op) state_d = in_mis ? S_DONE : S_REQ;
      S_REQ:   if (i_bus_req_ready) state_d = S_RSP;
      S_RSP:   if (i_bus_rsp_valid || rsp_tmo) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of every registered output, computed from the transition being taken
  always_comb begin
    store_d     = store_q;
    rdtype_d    = rdtype_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    cnt_d       = (state_q == S_RSP) ? cnt_q + CW'(1) : '0;
    ready_d     = (state_d == S_IDLE);
    req_vld_d   = (state_d == S_REQ);
    bus_addr_d  = 32'h0;
    bus_we_d    = 1'b0;
    bus_wstrb_d = 4'h0;
    bus_wdata_d = 32'h0;
    done_d      = (state_d == S_DONE);
    wb_en_d     = 1'b0;
    wb_rd_d     = 5'h0;
    wb_data_d   = 32'h0;
    exc_mis_d   = 1'b0;
    exc_acc_d   = 1'b0;
    exc_store_d = 1'b0;
    exc_addr_d  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (accept && in_op) begin
          store_d  = in_store;
          rdtype_d = i_mem_rdtype;
          addr_d   = i_mem_addr;
          rd_d     = i_rd_idx;
          if (in_mis) begin
            exc_mis_d   = 1'b1;
            exc_store_d = in_store;
            exc_addr_d  = i_mem_addr;
          end else begin
            bus_addr_d  = {i_mem_addr[31:2], 2'b00};
            bus_we_d    = in_store;
            bus_wstrb_d = in_store ? st_wstrb : 4'h0;
            bus_wdata_d = in_store ? st_wdata : 32'h0;
          end
        end
      end
      S_REQ: begin
        if (state_d == S_REQ) begin
          bus_addr_d  = bus_addr_q;
          bus_we_d    = bus_we_q;
          bus_wstrb_d = bus_wstrb_q;
          bus_wdata_d = bus_wdata_q;
        end
      end
      S_RSP: begin
        if (state_d == S_DONE) begin
          if (i_bus_rsp_valid && !i_bus_rsp_err) begin
            if (!store_q) begin
              wb_en_d   = 1'b1;
              wb_rd_d   = rd_q;
              wb_data_d = ld_data;
            end
          end else begin
            exc_acc_d   = 1'b1;
            exc_store_d = store_q;
            exc_addr_d  = addr_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      store_q     <= 1'b0;
      rdtype_q    <= 4'h0;
      addr_q      <= 32'h0;
      rd_q        <= 5'h0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      req_vld_q   <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= 4'h0;
      bus_wdata_q <= 32'h0;
      done_q      <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= 5'h0;
      wb_data_q   <= 32'h0;
      exc_mis_q   <= 1'b0;
      exc_acc_q   <= 1'b0;
      exc_store_q <= 1'b0;
      exc_addr_q  <= 32'h0;
    end else begin
      store_q     <= store_d;
      rdtype_q    <= rdtype_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      req_vld_q   <= req_vld_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      wb_en_q     <= wb_en_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_mis_q   <= exc_mis_d;
      exc_acc_q   <= exc_acc_d;
      exc_store_q <= exc_store_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign o_lsu_ready     = ready_q;
  assign o_bus_req_valid = req_vld_q;
  assign o_bus_addr      = bus_addr_q;
  assign o_bus_we        = bus_we_q;
  assign o_bus_wstrb     = bus_wstrb_q;
  assign o_bus_wdata     = bus_wdata_q;
  assign o_lsu_done      = done_q;
  assign o_wb_en         = wb_en_q;
  assign o_wb_rd         = wb_rd_q;
  assign o_wb_data       = wb_data_q;
  assign o_exc_misalign  = exc_mis_q;
  assign o_exc_access    = exc_acc_q;
  assign o_exc_store     = exc_store_q;
  assign o_exc_addr      = exc_addr_q;

endmodule

// File: tb/tb_exu_lsu.sv
// Directed bench for exu_lsu: vector table for single ops plus stall, timeout and reset sequences.
module tb_exu_lsu;
  localparam int TMO = 256;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_lsu_valid, i_mem_wreq, i_mem_rreq;
  logic [2:0]  i_mem_wtype;
  logic [3:0]  i_mem_rdtype;
  logic [31:0] i_mem_addr, i_mem_wdata;
  logic [4:0]  i_rd_idx;
  logic        o_lsu_ready, o_bus_req_valid, i_bus_req_ready, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata, i_bus_rdata, o_wb_data, o_exc_addr;
  logic [3:0]  o_bus_wstrb;
  logic        i_bus_rsp_valid, i_bus_rsp_err;
  logic        o_lsu_done, o_wb_en, o_exc_misalign, o_exc_access, o_exc_store;
  logic [4:0]  o_wb_rd;

  exu_lsu #(.RSP_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
    .i_mem_wreq(i_mem_wreq), .i_mem_rreq(i_mem_rreq),
    .i_mem_wtype(i_mem_wtype), .i_mem_rdtype(i_mem_rdtype),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_rd_idx(i_rd_idx),
    .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
    .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we), .o_bus_wstrb(o_bus_wstrb),
    .o_bus_wdata(o_bus_wdata), .i_bus_rsp_valid(i_bus_rsp_valid),
    .i_bus_rdata(i_bus_rdata), .i_bus_rsp_err(i_bus_rsp_err),
    .o_lsu_done(o_lsu_done), .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_exc_misalign(o_exc_misalign),
    .o_exc_access(o_exc_access), .o_exc_store(o_exc_store), .o_exc_addr(o_exc_addr)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wreq;
    logic        rreq;
    logic [2:0]  wtype;
    logic [3:0]  rdtype;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        exp_req;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
    logic        exp_mis;
    logic        exp_acc;
  } vec_t;

  vec_t vecs[16];

  task automatic offer(input logic wreq, input logic rreq, input logic [2:0] wtype,
                       input logic [3:0] rdtype, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    i_lsu_valid  = 1'b1;
    i_mem_wreq   = wreq;
    i_mem_rreq   = rreq;
    i_mem_wtype  = wtype;
    i_mem_rdtype = rdtype;
    i_mem_addr   = addr;
    i_mem_wdata  = wdata;
    i_rd_idx     = rd;
  endtask

  task automatic unoffer();
    i_lsu_valid = 1'b0;
    i_mem_wreq  = 1'b0;
    i_mem_rreq  = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   n;
    logic exc;

    //       wreq rreq wtype   rdtype   addr          wdata         rdata         err req baddr         wstrb    exp_wdata     wb  wb_data       mis acc
    vecs[0]  = '{0, 1, 3'b000, 4'b1100, 32'h0000_1003, 32'h0,        32'h80AA_55CC, 0, 1, 32'h0000_1000, 4'b0000, 32'h0,        1, 32'hFFFF_FF80, 0, 0};
    vecs[1]  = '{0, 1, 3'b000, 4'b0010, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,        1, 32'h0000_BEEF, 0, 0};
    vecs[2]  = '{0, 1, 3'b000, 4'b0100, 32'h0000_2001, 32'h0,        32'hBEEF_1234, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,        1, 32'h0000_0012, 0, 0};
    vecs[3]  = '{0, 1, 3'b000, 4'b1010, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1, 32'h0000_2000, 4'b0000, 32'h0,        1, 32'hFFFF_BEEF, 0, 0};
    vecs[4]  = '{0, 1, 3'b000, 4'b0001, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h0000_3000, 4'b0000, 32'h0,        1, 32'hDEAD_BEEF, 0, 0};
    vecs[5]  = '{1, 0, 3'b010, 4'b0000, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        0, 1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,        0, 0};
    vecs[6]  = '{1, 0, 3'b100, 4'b0000, 32'h0000_2001, 32'h0000_00A5, 32'h0,        0, 1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 0, 32'h0,        0, 0};
    vecs[7]  = '{1, 0, 3'b001, 4'b0000, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        0, 1, 32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 0, 32'h0,        0, 0};
    vecs[8]  = '{0, 1, 3'b000, 4'b0001, 32'h0000_1001, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 0};
    vecs[9]  = '{1, 0, 3'b001, 4'b0000, 32'h0000_1002, 32'h5555_5555, 32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 0};
    vecs[10] = '{0, 1, 3'b000, 4'b1010, 32'h0000_1003, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1, 0};
    vecs[11] = '{0, 1, 3'b000, 4'b0001, 32'h0000_5000, 32'h0,        32'h1111_2222, 1, 1, 32'h0000_5000, 4'b0000, 32'h0,        0, 32'h0,        0, 1};
    vecs[12] = '{1, 1, 3'b001, 4'b0001, 32'h0000_6000, 32'h55AA_55AA, 32'h1234_5678, 0, 1, 32'h0000_6000, 4'b1111, 32'h55AA_55AA, 0, 32'h0,        0, 0};
    vecs[13] = '{0, 1, 3'b000, 4'b1100, 32'h0000_7000, 32'h0,        32'h0000_007F, 0, 1, 32'h0000_7000, 4'b0000, 32'h0,        1, 32'h0000_007F, 0, 0};
    vecs[14] = '{1, 0, 3'b100, 4'b0000, 32'h0000_2003, 32'hFFFF_FFC3, 32'h0,        0, 1, 32'h0000_2000, 4'b1000, 32'hC3C3_C3C3, 0, 32'h0,        0, 0};
    vecs[15] = '{1, 0, 3'b010, 4'b0000, 32'h0000_2000, 32'hAAAA_5678, 32'h0,        0, 1, 32'h0000_2000, 4'b0011, 32'h5678_5678, 0, 32'h0,        0, 0};

    i_rst = 1'b1;
    unoffer();
    i_mem_wtype = '0; i_mem_rdtype = '0; i_mem_addr = '0; i_mem_wdata = '0; i_rd_idx = '0;
    i_bus_req_ready = 1'b1; i_bus_rsp_valid = 1'b0; i_bus_rdata = '0; i_bus_rsp_err = 1'b0;

    repeat (2) @(negedge i_clk);
    chk("rst_ready", o_lsu_ready, 1);
    chk("rst_req_valid", o_bus_req_valid, 0);
    chk("rst_done", o_lsu_done, 0);
    chk("rst_wstrb", o_bus_wstrb, 0);
    chk("rst_wb_en", o_wb_en, 0);
    chk("rst_exc_addr", o_exc_addr, 0);
    i_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      exc = v.exp_mis | v.exp_acc;
      @(negedge i_clk);
      chk($sformatf("v%0d_idle_ready", i), o_lsu_ready, 1);
      offer(v.wreq, v.rreq, v.wtype, v.rdtype, v.addr, v.wdata, 5'(i + 1));
      @(negedge i_clk);
      unoffer();
      chk($sformatf("v%0d_busy_ready", i), o_lsu_ready, 0);
      if (v.exp_req) begin
        chk($sformatf("v%0d_req_valid", i), o_bus_req_valid, 1);
        chk($sformatf("v%0d_bus_addr", i), o_bus_addr, v.exp_baddr);
        chk($sformatf("v%0d_bus_we", i), o_bus_we, v.wreq);
        chk($sformatf("v%0d_bus_wstrb", i), o_bus_wstrb, v.exp_wstrb);
        if (v.wreq) chk($sformatf("v%0d_bus_wdata", i), o_bus_wdata, v.exp_wdata);
        chk($sformatf("v%0d_early_done", i), o_lsu_done, 0);
        @(negedge i_clk);
        chk($sformatf("v%0d_req_dropped", i), o_bus_req_valid, 0);
        i_bus_rsp_valid = 1'b1;
        i_bus_rdata     = v.rdata;
        i_bus_rsp_err   = v.err;
        @(negedge i_clk);
        i_bus_rsp_valid = 1'b0;
        i_bus_rsp_err   = 1'b0;
      end else begin
        chk($sformatf("v%0d_no_req", i), o_bus_req_valid, 0);
      end
      chk($sformatf("v%0d_done", i), o_lsu_done, 1);
      chk($sformatf("v%0d_wb_en", i), o_wb_en, v.exp_wb_en);
      chk($sformatf("v%0d_wb_rd", i), o_wb_rd, v.exp_wb_en ? 5'(i + 1) : 5'd0);
      chk($sformatf("v%0d_wb_data", i), o_wb_data, v.exp_wb_data);
      chk($sformatf("v%0d_misalign", i), o_exc_misalign, v.exp_mis);
      chk($sformatf("v%0d_access", i), o_exc_access, v.exp_acc);
      chk($sformatf("v%0d_exc_store", i), o_exc_store, exc ? v.wreq : 1'b0);
      chk($sformatf("v%0d_exc_addr", i), o_exc_addr, exc ? v.addr : 32'h0);
      @(negedge i_clk);
      chk($sformatf("v%0d_done_pulse", i), o_lsu_done, 0);
    end

    // Stalled request, response during handshake ignored, then error response
    @(negedge i_clk);
    i_bus_req_ready = 1'b0;
    offer(1'b1, 1'b0, 3'b001, 4'b0000, 32'h0000_8004, 32'h1122_3344, 5'd9);
    @(negedge i_clk);
    unoffer();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_req_valid", k), o_bus_req_valid, 1);
      chk($sformatf("stall%0d_addr", k), o_bus_addr, 32'h0000_8004);
      chk($sformatf("stall%0d_wstrb", k), o_bus_wstrb, 4'b1111);
      chk($sformatf("stall%0d_wdata", k), o_bus_wdata, 32'h1122_3344);
      chk($sformatf("stall%0d_ready", k), o_lsu_ready, 0);
      @(negedge i_clk);
    end
    i_bus_req_ready = 1'b1;
    i_bus_rsp_valid = 1'b1;
    i_bus_rsp_err   = 1'b1;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_err   = 1'b0;
    chk("hs_rsp_req_valid", o_bus_req_valid, 0);
    chk("hs_rsp_ignored", o_lsu_done, 0);
    @(negedge i_clk);
    chk("hs_rsp_still_waiting", o_lsu_done, 0);
    i_bus_rsp_valid = 1'b1;
    i_bus_rsp_err   = 1'b1;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    i_bus_rsp_err   = 1'b0;
    chk("err_done", o_lsu_done, 1);
    chk("err_access", o_exc_access, 1);
    chk("err_store", o_exc_store, 1);
    chk("err_addr", o_exc_addr, 32'h0000_8004);
    chk("err_wb_en", o_wb_en, 0);

    // Response timeout, then a late response
    @(negedge i_clk);
    offer(1'b0, 1'b1, 3'b000, 4'b0001, 32'h0000_9000, 32'h0, 5'd3);
    @(negedge i_clk);
    unoffer();
    @(negedge i_clk);
    n = 0;
    while (!o_lsu_done && n < TMO + 100) begin
      n++;
      @(negedge i_clk);
    end
    chk("tmo_cycles", n, TMO);
    chk("tmo_access", o_exc_access, 1);
    chk("tmo_addr", o_exc_addr, 32'h0000_9000);
    chk("tmo_wb_en", o_wb_en, 0);
    i_bus_rsp_valid = 1'b1;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    chk("tmo_late_rsp0", o_lsu_done, 0);
    @(negedge i_clk);
    chk("tmo_late_rsp1", o_lsu_done, 0);

    // Asynchronous reset while waiting for a response
    offer(1'b0, 1'b1, 3'b000, 4'b0001, 32'h0000_A000, 32'h0, 5'd4);
    @(negedge i_clk);
    unoffer();
    @(negedge i_clk);
    chk("mid_rsp_ready", o_lsu_ready, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_ready", o_lsu_ready, 1);
    chk("arst_req_valid", o_bus_req_valid, 0);
    chk("arst_done", o_lsu_done, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_bus_rsp_valid = 1'b1;
    i_bus_rdata     = 32'h7777_7777;
    @(negedge i_clk);
    i_bus_rsp_valid = 1'b0;
    chk("post_rst_no_done0", o_lsu_done, 0);
    chk("post_rst_ready", o_lsu_ready, 1);
    @(negedge i_clk);
    chk("post_rst_no_done1", o_lsu_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
